// File: rtl/vbutton_ctrl.sv
// Three-channel push-button conditioner: synchronise, debounce, detect the
// press edge and toggle one control level per accepted press.
module vbutton_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_dir,
  input  logic       btn_sel,
  output logic       pause,
  output logic       decrement,
  output logic       sel,
  output logic [2:0] press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    stable;
  logic [2:0]    tog;
  logic [2:0]    accept;
  logic [2:0]    rise;
  logic [CW-1:0] cnt [3];

  assign raw = {btn_sel, btn_dir, btn_pause};

  // accept: s2 has now differed from stable on DEBOUNCE_CYCLES consecutive edges
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
    rise = accept & s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      tog    <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1    <= raw;
      s2    <= s1;
      tog   <= tog ^ rise;
      press <= rise;
      for (int unsigned i = 0; i < 3; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]    <= '0;
          stable[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign pause     = tog[0];
  assign decrement = tog[1];
  assign sel       = tog[2];

endmodule

// File: tb/tb_vbutton_ctrl.sv
// Scoreboard bench for vbutton_ctrl: a window-based reference model predicts
// every cycle's outputs; a monitor pops and compares them on the falling edge.
module tb_vbutton_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_dir = 1'b0;
  logic       btn_sel = 1'b0;
  logic       pause;
  logic       decrement;
  logic       sel;
  logic [2:0] press;

  vbutton_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pause (btn_pause),
    .btn_dir   (btn_dir),
    .btn_sel   (btn_sel),
    .pause     (pause),
    .decrement (decrement),
    .sel       (sel),
    .press     (press)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pc [3] = '{0, 0, 0};
  int cnt_max = 0;
  logic [5:0] expq [$];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: raw samples since reset; the synchronised view of a
  // button lags the raw sample by two edges. A new level is accepted when the
  // last D synchronised samples all equal it and it differs from the accepted one.
  logic [2:0] rq [$];
  logic [2:0] xq [$];
  logic [2:0] m_stable = '0;
  logic [2:0] m_tog = '0;
  logic [2:0] m_prs = '0;

  always @(posedge clk) begin
    logic [2:0] x;
    logic       all_same;
    if (rst) begin
      rq.delete();
      xq.delete();
      m_stable = '0;
      m_tog    = '0;
      m_prs    = '0;
    end else begin
      rq.push_back({btn_sel, btn_dir, btn_pause});
      x = (rq.size() >= 3) ? rq[rq.size() - 3] : 3'b000;
      if (rq.size() > 3) void'(rq.pop_front());
      xq.push_back(x);
      if (xq.size() > D) void'(xq.pop_front());
      m_prs = '0;
      for (int c = 0; c < 3; c++) begin
        all_same = (xq.size() == D);
        foreach (xq[j]) if (xq[j][c] != x[c]) all_same = 1'b0;
        if (all_same && (x[c] != m_stable[c])) begin
          m_stable[c] = x[c];
          if (x[c]) begin
            m_tog[c] = ~m_tog[c];
            m_prs[c] = 1'b1;
          end
        end
      end
    end
    expq.push_back({m_tog[0], m_tog[1], m_tog[2], m_prs});
  end

  always @(negedge clk) begin
    logic [5:0] e;
    for (int c = 0; c < 3; c++) if (press[c]) pc[c]++;
    if (int'(dut.cnt[0]) > cnt_max) cnt_max = int'(dut.cnt[0]);
    if (int'(dut.cnt[1]) > cnt_max) cnt_max = int'(dut.cnt[1]);
    if (int'(dut.cnt[2]) > cnt_max) cnt_max = int'(dut.cnt[2]);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("out", int'({pause, decrement, sel, press}), int'(e));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int p;
  int rem [3] = '{0, 0, 0};
  logic [2:0] lvl = '0;

  initial begin
    step(2);
    @(negedge clk); #1 rst = 1'b0;
    step(1);

    // all three rise together
    btn_pause = 1'b1; btn_dir = 1'b1; btn_sel = 1'b1;
    step(5);
    chk("simul_before", int'({pause, decrement, sel, press}), 0);
    step(1);
    chk("simul_levels", int'({pause, decrement, sel}), 7);
    chk("simul_press", int'(press), 7);
    step(1);
    chk("simul_press_end", int'(press), 0);
    step(3);

    // asynchronous reset mid-cycle, pause held through release
    @(negedge clk); #1 rst = 1'b1;
    #1 chk("async_reset", int'({pause, decrement, sel, press}), 0);
    btn_dir = 1'b0; btn_sel = 1'b0;
    step(2);
    @(negedge clk); #1 rst = 1'b0;
    step(5);
    chk("rst_hold_edge5", int'(pause), 0);
    step(1);
    chk("rst_hold_edge6", int'(pause), 1);
    chk("rst_hold_press", int'(press), 1);
    step(1);
    chk("rst_hold_press_end", int'(press), 0);
    btn_pause = 1'b0;
    step(10);

    // clean presses on dir
    p = pc[1];
    btn_dir = 1'b1; step(20);
    chk("clean1_level", int'(decrement), 1);
    chk("clean1_pulses", pc[1] - p, 1);
    btn_dir = 1'b0; step(10);
    btn_dir = 1'b1; step(20);
    chk("clean2_level", int'(decrement), 0);
    chk("clean2_pulses", pc[1] - p, 2);
    btn_dir = 1'b0; step(10);

    // bounce rejection on sel
    p = pc[2];
    for (int i = 0; i < 40; i++) begin
      btn_sel = (i % 4 != 3);
      step(1);
    end
    chk("bounce_level", int'(sel), 0);
    chk("bounce_pulses", pc[2] - p, 0);
    btn_sel = 1'b1; step(6);
    chk("bounce_then_hold", int'(sel), 1);
    btn_sel = 1'b0; step(10);

    // release bounce on dir
    p = pc[1];
    btn_dir = 1'b1; step(10);
    chk("rb_press", int'(decrement), 1);
    for (int i = 0; i < 30; i++) begin
      btn_dir = (i % 5 >= 3);
      step(1);
    end
    chk("rb_glitch_pulses", pc[1] - p, 1);
    btn_dir = 1'b0; step(10);
    chk("rb_release_level", int'(decrement), 1);
    btn_dir = 1'b1; step(10);
    chk("rb_repress_level", int'(decrement), 0);
    chk("rb_total_pulses", pc[1] - p, 2);
    btn_dir = 1'b0; step(10);

    // long hold
    p = pc[0];
    btn_pause = 1'b1; step(1000);
    chk("long_hold_pulses", pc[0] - p, 1);
    chk("long_hold_level", int'(pause), 0);
    btn_pause = 1'b0; step(10);

    // random run-length stimulus
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          rem[c] = int'($urandom_range(1, 8));
        end
        rem[c]--;
      end
      btn_pause = lvl[0]; btn_dir = lvl[1]; btn_sel = lvl[2];
      step(1);
    end
    btn_pause = 1'b0; btn_dir = 1'b0; btn_sel = 1'b0;
    step(10);

    chk("cnt_bound", int'(cnt_max <= D - 1), 1);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vbutton_ctrl.md
# vbutton_ctrl

Input-conditioning stage that sits directly upstream of the 3-bit counter and display-select mux. Takes three raw, bouncy push buttons on the fast board clock and produces clean control levels for the counter and mux: `pause`, `decrement` and `sel`. Each button is synchronised, debounced, edge-detected and converted to a toggle, so one physical press flips one control exactly once. Each button also gets a one-cycle press pulse for debug and other consumers.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a new button level. Legal range is ≥ 2. Counter width is $clog2(DEBOUNCE_CYCLES).
- `clk`  in  1  board clock (same net as the clock generator input, undivided)
- `rst`  in  1  asynchronous, active-high reset
- `btn_pause`  in  1  raw push button, asynchronous to `clk`, active-high
- `btn_dir`  in  1  raw push button, asynchronous, active-high
- `btn_sel`  in  1  raw push button, asynchronous, active-high
- `pause`  out  1  toggled level; 1 = counter holds
- `decrement`  out  1  toggled level; 1 = counter counts down
- `sel`  out  1  toggled level; 1 = display converted value
- `press`  out  3  one-cycle pulses, [0]=pause, [1]=dir, [2]=sel

## Operation
- The three channels are identical and fully independent; no arbitration between them.
- **Per-channel pipeline:** 2-flop synchroniser (`s1`, `s2`), then debounce counter `cnt`, then accepted level `stable`, then rising-edge detect, then toggle register.
- **Debounce rule, evaluated every cycle:**
  - If `s2 == stable`: `cnt` <= 0.
  - If `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` <= `cnt`+1.
  - If `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable` <= `s2` and `cnt` <= 0.
- Net effect: `stable` changes only after `s2` has differed from it on DEBOUNCE_CYCLES consecutive edges.
- Any glitch back to the old level restarts the count from 0; there is no partial credit.
- **Press:** on the edge where `stable` goes 0→1, the toggle output inverts and `press[i]` is 1 for exactly the following cycle.
- **Release:** a 1→0 transition of `stable` is debounced identically but produces no pulse and no toggle.
- Holding a button produces a single toggle, with no auto-repeat.
- Outputs are registered; there is no combinational path from the `btn_*` inputs to any output.

## Timing
- **Reset values:** `s1`, `s2`, `stable` and `cnt` are 0 in all channels; `pause`=0, `decrement`=0, `sel`=0, `press`=3'b000.
- Reset acts immediately, with no clock needed. Reset mid-debounce discards the partial count.
- A button held through reset release counts as a press: it is accepted after debounce and produces one toggle.
- **Latency:** raw input steady 1 before edge k
  - `s2`=1 after edge k+1.
  - `stable`, toggle and `press` update at edge k+1+DEBOUNCE_CYCLES.
  - `press` is high during the cycle after that edge.
- **Minimum press:** a press shorter than DEBOUNCE_CYCLES+2 cycles may be ignored. One lasting DEBOUNCE_CYCLES+2 or more cycles is always accepted.
- **Simultaneous presses** on several channels toggle each affected output on the same edge.
- **Counter wrap:** `cnt` never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around.
- **Downstream sampling:** the counter samples the toggled levels on the divided clock. The levels are quasi-static, so no extra handshake is required. `press` pulses are fast-domain only and must not be used by the divided-clock logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** assert `rst` asynchronously mid-cycle with all buttons high → all outputs 0 immediately. Release `rst` with `btn_pause` still high → `pause`=1 at edge 6 after release, and `press[0]` pulses once.
- **Clean press:** `btn_dir` 0→1 before edge 0, held 20 cycles → `decrement` 0→1 at edge 5, `press[1]` high for exactly one cycle, then a single toggle only. A second clean press later → `decrement` returns to 0.
- **Bounce rejection:** `btn_sel` pattern 1,1,1,0,1,1,1,0 repeating (3-cycle runs) for 40 cycles → `sel` stays 0 and `press[2]` never pulses. Then hold 1 for 6 cycles → `sel`=1.
- **Release bounce:** after an accepted press, drop the button with 2-cycle glitches back to 1 for 30 cycles, then a clean press → exactly one additional toggle, and none during the glitches.
- **Simultaneous:** all three buttons rise on the same cycle and are held → `pause`, `decrement` and `sel` all become 1 on the same edge, and `press`=3'b111 for one cycle.
- **Long hold:** `btn_pause` held 1000 cycles → exactly one `press[0]` pulse, and `cnt` never exceeds 3.
